// File: rtl/delay_sched_pkg.sv
// Shared types and constants for the delay-channel scheduler slice.
package delay_sched_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 24;

  localparam logic [DEF_N_CH-1:0] ALL_CH = {DEF_N_CH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/delay_channel_scheduler_slot.sv
// One output channel: delay/enable config, fired flag, comparator and
// the registered discharge-release pulse.
module delay_ch_slot #(
  parameter int CNT_W = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic             force_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic             ena_i,
  output logic             ena_o,
  output logic             fired_o,
  output logic             pulse_o
);

  logic [CNT_W-1:0] delay_q;
  logic             ena_q;
  logic             fired_q;
  logic             pulse_q;
  logic             match;

  assign match = run_i && ena_q && !fired_q && (cnt_i == delay_q);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      delay_q <= '0;
      ena_q   <= 1'b0;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      if (we_i) begin
        delay_q <= delay_i;
        ena_q   <= ena_i;
      end
      if (clear_i)
        fired_q <= 1'b0;
      else if (match)
        fired_q <= 1'b1;
      // An abort forces every channel safe regardless of its compare.
      pulse_q <= force_i || match;
    end
  end

  assign ena_o   = ena_q;
  assign fired_o = fired_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/delay_channel_scheduler.sv
// Sequences per-channel discharge-release pulses from one shared counter
// launched by a start edge; owns the per-channel delay configuration.
module delay_channel_scheduler
  import delay_sched_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [CNT_W-1:0] i_cfg_delay,
  input  logic             i_cfg_ena,
  input  logic             i_arm,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [N_CH-1:0]  o_reset_ch,
  output logic             o_armed,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cfg_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_prev_q;
  logic             armed_q, busy_q, done_q, cfg_err_q;
  logic             cfg_err_d;
  logic             start_edge;
  logic             clear_fired;
  logic             abort_fire;
  logic             run_cmp;
  logic             all_fired;
  logic [N_CH-1:0]  wr_sel, ena_vec, ena_eff, fired_vec, pulse_vec;

  assign start_edge = i_start && !start_prev_q;
  assign run_cmp    = (state_q == ST_RUN) && !i_abort;
  assign all_fired  = &(fired_vec | ~ena_vec);

  for (genvar c = 0; c < N_CH; c++) begin : g_slot
    assign wr_sel[c]  = i_cfg_we && (state_q == ST_IDLE) && (i_cfg_ch == CH_W'(c));
    // Arm checks enables as they will be after a same-cycle write.
    assign ena_eff[c] = wr_sel[c] ? i_cfg_ena : ena_vec[c];

    delay_ch_slot #(.CNT_W(CNT_W)) u_slot (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .cnt_i   (cnt_q),
      .run_i   (run_cmp),
      .clear_i (clear_fired),
      .force_i (abort_fire),
      .we_i    (wr_sel[c]),
      .delay_i (i_cfg_delay),
      .ena_i   (i_cfg_ena),
      .ena_o   (ena_vec[c]),
      .fired_o (fired_vec[c]),
      .pulse_o (pulse_vec[c])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clear_fired = 1'b0;
    abort_fire  = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_arm) begin
          if (|ena_eff) begin
            state_d     = ST_ARMED;
            clear_fired = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (i_abort) begin
          state_d    = ST_IDLE;
          abort_fire = 1'b1;
        end else if (start_edge) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          state_d    = ST_IDLE;
          abort_fire = 1'b1;
        end else begin
          if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
          if (all_fired)
            state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_cfg_we && (state_q != ST_IDLE))
      cfg_err_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_prev_q <= i_start;
      armed_q      <= (state_d == ST_ARMED);
      busy_q       <= (state_d == ST_ARMED) || (state_d == ST_RUN);
      done_q       <= (state_d == ST_DONE);
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign o_reset_ch = pulse_vec;
  assign o_armed    = armed_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_cfg_err  = cfg_err_q;

endmodule
